icache: RTL and testbench
=========================

# icache

Direct-mapped, single-word-block instruction cache sitting between the fetch stage and the instruction RAM port. It answers fetch requests (`imemREN`/`imemaddr`) with `ihit`/`imemload` in the same cycle on a hit. On a miss it issues one word read to RAM, fills the line and then reports the hit. It also supports a full invalidate (`iflush`) for halt and self-modifying-code handling.

## Interface
Parameters:
- `SETS`, 16: number of lines; power of two, minimum 2.
- `IDXW`, $clog2(SETS): index width (4 at default).

Ports. One clock; reset is synchronous and active-high.
- `CLK`, in, 1: clock; all state updates on the rising edge.
- `RST`, in, 1: synchronous active-high reset.
- `imemREN`, in, 1: fetch requests a word.
- `imemaddr`, in, 32: fetch byte address. Bits [1:0] are ignored.
- `iflush`, in, 1: invalidate all lines.
- `ihit`, out, 1: `imemload` is valid for `imemaddr` this cycle.
- `imemload`, out, 32: instruction word; 0 when `ihit`=0.
- `iREN`, out, 1: RAM read request.
- `iaddr`, out, 32: RAM word address, with bits [1:0]=0.
- `iload`, in, 32: RAM read data; valid when `iwait`=0.
- `iwait`, in, 1: RAM busy. 1 means data not ready.

## Operation
- Address split: index = `imemaddr[IDXW+1:2]`, tag = `imemaddr[31:IDXW+2]`.
- Per line: `valid` (1), `tag` (32-IDXW-2), `data` (32).
- Hit = `imemREN` & `valid[idx]` & (`tag[idx]`==tag) & ~`iflush`. `ihit` and `imemload` are combinational from the stored line.
- FSM states: IDLE, FILL.
  - IDLE to FILL: `imemREN` & ~hit & ~`iflush`. On this edge, latch `miss_addr` = {`imemaddr[31:2]`,2'b00}.
  - FILL: `iREN`=1 and `iaddr`=`miss_addr`. The `imemaddr` and `imemREN` inputs are ignored for the fill.
  - FILL to IDLE: when `iwait`=0. On this edge write `data`=`iload` and `tag`=`miss_addr` tag at the `miss_addr` index, and set `valid`=1.
  - In IDLE: `iREN`=0; `iaddr` holds the last `miss_addr`.
- `ihit`=0 throughout FILL, even if the current `imemaddr` would hit another line. There is no hit-under-miss.
- Redirect mid-miss: if `imemaddr` changes or `imemREN` drops during FILL, the latched fill still completes and is written. The next IDLE cycle evaluates the new address.
- Flush:
  - `iflush`=1 clears every `valid` bit at the next edge and forces `ihit`=0 that cycle.
  - In IDLE, flush prevents entry to FILL.
  - In FILL, the RAM read still runs to completion (the FSM stays in FILL until `iwait`=0). A fill completing on or after a flush edge within the same miss is discarded: no write, valid stays 0. Track this with a `drop` flag that is set by flush in FILL and cleared on exit.
- Reset:
  - State: IDLE.
  - All `valid`=0, `miss_addr`=0, `drop`=0.
  - Outputs: `iREN`=0, `iaddr`=0, `ihit`=0, `imemload`=0.
  - Tag and data arrays need not be reset.
  - Reset during FILL abandons the request immediately: `iREN` is 0 in the cycle after the reset edge.

## Timing
- Hit: 0-cycle latency. `ihit` is asserted in the same cycle as `imemREN`/`imemaddr`.
- Miss with RAM wait of N cycles (`iwait` high N cycles after `iREN` rises):
  - Cycle 0: miss detected in IDLE.
  - Cycles 1..N+1: FILL. Fill written at the end of cycle N+1.
  - Cycle N+2: `ihit`=1.
  - Total penalty: N+2 cycles. With N=0 the penalty is 2 cycles.
- `iREN` is asserted continuously from the first FILL cycle through the cycle in which `iwait`=0. It drops the following cycle.
- Back-to-back misses: at least one IDLE cycle separates consecutive FILL periods.
- Same-index conflict: a fill overwrites the line unconditionally, whether or not it was valid.

## Test plan
- Reset then cold miss:
  - Stimulus: RST high for 2 cycles, then `imemREN`=1, `imemaddr`=0x0000_0040, with RAM returning 0x2001_0005 after `iwait` high for 2 cycles.
  - Required response: `iREN`=1 and `iaddr`=0x40 for 3 cycles, `ihit`=0 throughout, then `ihit`=1 and `imemload`=0x2001_0005 in the cycle after the fill.
- Hit after fill:
  - Stimulus: re-request 0x40, then 0x43.
  - Required response: `ihit`=1 the same cycle and `iREN`=0 for both; low bits are ignored.
- Conflict eviction:
  - Stimulus: fill 0x0000_0000 (data 0xAAAA_AAAA), then 0x0000_0100 (data 0xBBBB_BBBB, same index at SETS=16), then request 0x0000_0000 again.
  - Required response: the final request misses and refetches `iaddr`=0x0.
- Redirect mid-miss:
  - Stimulus: miss on 0x80, then change `imemaddr` to 0x84 during FILL.
  - Required response: `iaddr` stays 0x80 and line 0x80 is filled. 0x84 then misses and fills in the next FILL, with at least 1 IDLE cycle in between.
- Flush:
  - Stimulus: with 0x40 valid, pulse `iflush` during a FILL of 0x80.
  - Required response: the FILL still waits for `iwait`=0, with no write of 0x80. Afterwards, both 0x40 and 0x80 miss.
- Reset mid-FILL:
  - Stimulus: assert RST while `iwait`=1.
  - Required response: `iREN`=0 the next cycle, all previously valid lines miss, and the state is IDLE.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped, single-word-block instruction cache between fetch and the
// instruction RAM port. Hits answer combinationally; misses do one RAM read.
module icache #(
    parameter int SETS = 16,
    parameter int IDXW = $clog2(SETS)
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    input  logic        iflush,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
);
    localparam int TAGW = 32 - IDXW - 2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t              state, next_state;
    logic [SETS-1:0]     valid;
    logic [TAGW-1:0]     tag_mem  [SETS];
    logic [31:0]         data_mem [SETS];
    logic [29:0]         miss_word;
    logic                drop;

    logic [IDXW-1:0]     idx;
    logic [TAGW-1:0]     tag;
    logic [IDXW-1:0]     fill_idx;
    logic [TAGW-1:0]     fill_tag;
    logic                hit;
    logic                fill_done;
    logic                fill_write;
    logic                unused_low_bits;

    assign idx       = imemaddr[IDXW+1:2];
    assign tag       = imemaddr[31:IDXW+2];
    assign fill_idx  = miss_word[IDXW-1:0];
    assign fill_tag  = miss_word[29:IDXW];
    assign unused_low_bits = ^imemaddr[1:0];

    // No hit-under-miss: lookups are only answered from IDLE.
    assign hit = (state == IDLE) & imemREN & valid[idx] &
                 (tag_mem[idx] == tag) & ~iflush;

    assign ihit       = hit;
    assign imemload   = hit ? data_mem[idx] : '0;
    assign iREN       = (state == FILL);
    assign iaddr      = {miss_word, 2'b00};
    assign fill_done  = (state == FILL) & ~iwait;
    // A flush seen at any edge of this miss discards the returning word.
    assign fill_write = fill_done & ~drop & ~iflush & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (imemREN & ~hit & ~iflush) next_state = FILL;
            FILL: if (~iwait) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid     <= '0;
            miss_word <= '0;
            drop      <= 1'b0;
        end else begin
            if (state == IDLE && next_state == FILL) begin
                miss_word <= imemaddr[31:2];
            end
            if (fill_done) begin
                drop <= 1'b0;
            end else if (state == FILL && iflush) begin
                drop <= 1'b1;
            end
            if (iflush) begin
                valid <= '0;
            end else if (fill_write) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (fill_write) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= iload;
        end
    end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed cycle table for the protocol corner cases, then
// randomized traffic checked against a word-address lookup-table model.
module tb_icache;
    localparam int SETS = 16;

    logic        CLK = 1'b0;
    logic        RST, imemREN, iflush, iwait;
    logic [31:0] imemaddr, iload;
    logic        ihit, iREN;
    logic [31:0] imemload, iaddr;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    icache #(.SETS(SETS)) dut (
        .CLK(CLK), .RST(RST), .imemREN(imemREN), .imemaddr(imemaddr),
        .iflush(iflush), .ihit(ihit), .imemload(imemload), .iREN(iREN),
        .iaddr(iaddr), .iload(iload), .iwait(iwait)
    );

    typedef struct {
        logic        rst, ren;
        logic [31:0] addr;
        logic        flush, wt;
        logic [31:0] load;
        logic        e_hit;
        logic [31:0] e_load;
        logic        e_iren;
        logic [31:0] e_iaddr;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic ren, input logic [31:0] addr,
                       input logic flush, input logic wt, input logic [31:0] load,
                       input logic e_hit, input logic [31:0] e_load,
                       input logic e_iren, input logic [31:0] e_iaddr);
        vec_t v;
        v.rst = rst; v.ren = ren; v.addr = addr; v.flush = flush; v.wt = wt;
        v.load = load; v.e_hit = e_hit; v.e_load = e_load; v.e_iren = e_iren;
        v.e_iaddr = e_iaddr;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int cyc,
                       input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %h expected %h", name, cyc, got, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic ren, input logic [31:0] addr,
                         input logic flush, input logic wt, input logic [31:0] load);
        @(negedge CLK);
        RST = rst; imemREN = ren; imemaddr = addr; iflush = flush;
        iwait = wt; iload = load;
        #1;
    endtask

    // Reference model: each set remembers which word address it holds.
    bit          m_v  [SETS];
    logic [29:0] m_wa [SETS];
    logic [31:0] m_d  [SETS];
    bit          m_fill, m_drop;
    logic [31:0] m_miss;

    function automatic int set_of(input logic [31:0] a);
        return int'((a >> 2) % SETS);
    endfunction

    task automatic model_reset();
        for (int unsigned i = 0; i < SETS; i++) m_v[i] = 1'b0;
        m_fill = 1'b0; m_drop = 1'b0; m_miss = '0;
    endtask

    function automatic bit model_hit(input logic ren, input logic [31:0] a,
                                     input logic flush);
        int s;
        s = set_of(a);
        return !m_fill && ren && !flush && m_v[s] && (m_wa[s] == a[31:2]);
    endfunction

    task automatic model_edge(input logic rst, input logic ren, input logic [31:0] a,
                              input logic flush, input logic wt, input logic [31:0] load);
        bit h;
        h = model_hit(ren, a, flush);
        if (rst) begin
            model_reset();
        end else begin
            if (flush) for (int unsigned i = 0; i < SETS; i++) m_v[i] = 1'b0;
            if (m_fill) begin
                if (!wt) begin
                    if (!m_drop && !flush) begin
                        m_v[set_of(m_miss)]  = 1'b1;
                        m_wa[set_of(m_miss)] = m_miss[31:2];
                        m_d[set_of(m_miss)]  = load;
                    end
                    m_fill = 1'b0; m_drop = 1'b0;
                end else if (flush) begin
                    m_drop = 1'b1;
                end
            end else if (ren && !h && !flush) begin
                m_fill = 1'b1;
                m_miss = {a[31:2], 2'b00};
            end
        end
    endtask

    localparam logic [31:0] D40 = 32'h2001_0005;
    localparam logic [31:0] DA  = 32'hAAAA_AAAA;
    localparam logic [31:0] DB  = 32'hBBBB_BBBB;
    localparam logic [31:0] D80 = 32'h1111_0080;
    localparam logic [31:0] D84 = 32'h2222_0084;

    initial begin
        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iflush = 1'b0;
        iwait = 1'b1; iload = '0;
        repeat (2) @(posedge CLK);

        //  rst ren addr    fl wt load          hit load iren iaddr
        // reset, then cold miss with two wait cycles
        add(1, 0, 32'h00, 0, 1, 0,            0, 0,   0, 32'h00);
        add(1, 0, 32'h00, 0, 1, 0,            0, 0,   0, 32'h00);
        add(0, 1, 32'h40, 0, 1, 0,            0, 0,   0, 32'h00);
        add(0, 1, 32'h40, 0, 1, 0,            0, 0,   1, 32'h40);
        add(0, 1, 32'h40, 0, 1, 0,            0, 0,   1, 32'h40);
        add(0, 1, 32'h40, 0, 0, D40,          0, 0,   1, 32'h40);
        // hits, low address bits ignored
        add(0, 1, 32'h40, 0, 1, 0,            1, D40, 0, 32'h40);
        add(0, 1, 32'h43, 0, 1, 0,            1, D40, 0, 32'h40);
        // conflict eviction in set 0
        add(0, 1, 32'h000, 0, 0, 0,           0, 0,   0, 32'h40);
        add(0, 1, 32'h000, 0, 0, DA,          0, 0,   1, 32'h00);
        add(0, 1, 32'h000, 0, 1, 0,           1, DA,  0, 32'h00);
        add(0, 1, 32'h100, 0, 1, 0,           0, 0,   0, 32'h00);
        add(0, 1, 32'h100, 0, 0, DB,          0, 0,   1, 32'h100);
        add(0, 1, 32'h100, 0, 1, 0,           1, DB,  0, 32'h100);
        add(0, 1, 32'h000, 0, 1, 0,           0, 0,   0, 32'h100);
        add(0, 1, 32'h000, 0, 0, DA,          0, 0,   1, 32'h00);
        // redirect mid-miss
        add(0, 1, 32'h80, 0, 1, 0,            0, 0,   0, 32'h00);
        add(0, 1, 32'h84, 0, 1, 0,            0, 0,   1, 32'h80);
        add(0, 1, 32'h84, 0, 0, D80,          0, 0,   1, 32'h80);
        add(0, 1, 32'h84, 0, 1, 0,            0, 0,   0, 32'h80);
        add(0, 1, 32'h84, 0, 0, D84,          0, 0,   1, 32'h84);
        add(0, 1, 32'h84, 0, 1, 0,            1, D84, 0, 32'h84);
        add(0, 1, 32'h80, 0, 1, 0,            1, D80, 0, 32'h84);
        // make 0x40 valid again, then flush during a fill of 0x80
        add(0, 1, 32'h40, 0, 1, 0,            0, 0,   0, 32'h84);
        add(0, 1, 32'h40, 0, 0, D40,          0, 0,   1, 32'h40);
        add(0, 1, 32'h40, 0, 1, 0,            1, D40, 0, 32'h40);
        add(0, 1, 32'h80, 0, 1, 0,            0, 0,   0, 32'h40);
        add(0, 1, 32'h40, 1, 1, 0,            0, 0,   1, 32'h80);
        add(0, 0, 32'h40, 0, 1, 0,            0, 0,   1, 32'h80);
        add(0, 0, 32'h40, 0, 0, D80,          0, 0,   1, 32'h80);
        add(0, 1, 32'h84, 0, 1, 0,            0, 0,   0, 32'h80);
        add(0, 1, 32'h84, 0, 0, D84,          0, 0,   1, 32'h84);
        add(0, 1, 32'h80, 0, 1, 0,            0, 0,   0, 32'h84);
        add(0, 1, 32'h80, 0, 0, D80,          0, 0,   1, 32'h80);
        add(0, 1, 32'h40, 0, 1, 0,            0, 0,   0, 32'h80);
        add(0, 1, 32'h40, 0, 0, D40,          0, 0,   1, 32'h40);
        add(0, 1, 32'h84, 0, 1, 0,            1, D84, 0, 32'h40);
        // flush in IDLE masks a hit and blocks fill entry
        add(0, 1, 32'h84, 1, 1, 0,            0, 0,   0, 32'h40);
        add(0, 0, 32'h84, 0, 1, 0,            0, 0,   0, 32'h40);
        add(0, 1, 32'h40, 0, 1, 0,            0, 0,   0, 32'h40);
        add(0, 1, 32'h40, 0, 0, D40,          0, 0,   1, 32'h40);
        add(0, 1, 32'h40, 0, 1, 0,            1, D40, 0, 32'h40);
        // reset while RAM is busy
        add(0, 1, 32'h84, 0, 1, 0,            0, 0,   0, 32'h40);
        add(0, 0, 32'h84, 0, 1, 0,            0, 0,   1, 32'h84);
        add(1, 0, 32'h84, 0, 1, 0,            0, 0,   1, 32'h84);
        add(0, 0, 32'h84, 0, 1, 0,            0, 0,   0, 32'h00);
        add(0, 1, 32'h40, 0, 1, 0,            0, 0,   0, 32'h00);
        add(0, 1, 32'h40, 0, 0, D40,          0, 0,   1, 32'h40);
        add(0, 1, 32'h40, 0, 1, 0,            1, D40, 0, 32'h40);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i].rst, vq[i].ren, vq[i].addr, vq[i].flush, vq[i].wt, vq[i].load);
            chk("dir_ihit",     i, {31'b0, ihit}, {31'b0, vq[i].e_hit});
            chk("dir_imemload", i, imemload,      vq[i].e_load);
            chk("dir_iREN",     i, {31'b0, iREN}, {31'b0, vq[i].e_iren});
            chk("dir_iaddr",    i, iaddr,         vq[i].e_iaddr);
        end

        // randomized traffic over a small address pool so hits and conflicts recur
        apply(1, 0, 0, 0, 1, 0);
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        r_rst, r_ren, r_fl, r_wt, e_hit;
            logic [31:0] r_addr, r_load, e_load;
            r_rst  = ($urandom_range(0, 199) == 0);
            r_ren  = ($urandom_range(0, 9) < 8);
            r_addr = $urandom_range(0, 32'h3FF);
            r_fl   = ($urandom_range(0, 39) == 0);
            r_wt   = ($urandom_range(0, 1) == 1);
            r_load = $urandom;
            apply(r_rst, r_ren, r_addr, r_fl, r_wt, r_load);
            e_hit  = model_hit(r_ren, r_addr, r_fl);
            e_load = e_hit ? m_d[set_of(r_addr)] : 32'h0;
            chk("rnd_ihit",     c, {31'b0, ihit}, {31'b0, e_hit});
            chk("rnd_imemload", c, imemload,      e_load);
            chk("rnd_iREN",     c, {31'b0, iREN}, {31'b0, m_fill});
            chk("rnd_iaddr",    c, iaddr,         m_miss);
            model_edge(r_rst, r_ren, r_addr, r_fl, r_wt, r_load);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
